// File: rtl/alu_operand_stage.sv
// Pipelined ALU operand pre-processing stage: opcode decode into adder operands/carry-in,
// registered behind valid/ready. Define ALU_OPERAND_SKID_EN for a 2-entry skid buffer.

module alu_operand_lane (
  input  logic       a_i,
  input  logic       b_i,
  input  logic [2:0] op_i,
  output logic       amod_o,
  output logic       bmod_o
);
  always_comb begin
    amod_o = 1'b0;
    bmod_o = a_i;
    unique case (op_i)
      3'b001: bmod_o = ~a_i;
      3'b010: begin amod_o = a_i; bmod_o = b_i; end
      3'b100: begin amod_o = a_i; bmod_o = ~b_i; end
      3'b101: amod_o = 1'b1;
      3'b110: bmod_o = b_i;
      default: ; // PASS_A, INC_A and reserved share the A-pass path
    endcase
  end
endmodule

module alu_operand_stage #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [2:0]           in_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_amod,
  output logic [WIDTH-1:0]     out_bmod,
  output logic                 out_cin,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef struct packed {
    logic [WIDTH-1:0] amod;
    logic [WIDTH-1:0] bmod;
    logic             cin;
    logic             err;
  } item_t;

`ifdef ALU_OPERAND_SKID_EN
  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2} state_e;
`else
  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1} state_e;
`endif

  item_t  dec;
  item_t  out_q;
  state_e state_q, state_d;
  logic   out_vld_q;
  logic   accept, consume;
  logic   ld_out_in;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // ---------------- decode ----------------
  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    alu_operand_lane u_lane (
      .a_i    (in_a[g]),
      .b_i    (in_b[g]),
      .op_i   (in_op),
      .amod_o (dec.amod[g]),
      .bmod_o (dec.bmod[g])
    );
  end

  assign dec.cin = (in_op == 3'b001) || (in_op == 3'b011) || (in_op == 3'b100);
  assign dec.err = (in_op == 3'b111);

  assign accept  = in_valid && in_ready;
  assign consume = out_vld_q && out_ready;

  // ---------------- state register ----------------
`ifdef ALU_OPERAND_SKID_EN
  item_t skid_q;
  logic  in_rdy_q;
  logic  ld_skid, ld_out_skid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_EMPTY;
      out_vld_q <= 1'b0;
      in_rdy_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      out_vld_q <= (state_d != S_EMPTY);
      in_rdy_q  <= (state_d != S_TWO);
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_EMPTY;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_vld_q <= (state_d != S_EMPTY);
    end
  end
`endif

  // ---------------- next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY: if (accept) state_d = S_ONE;
      S_ONE: begin
        if (consume && !accept) state_d = S_EMPTY;
`ifdef ALU_OPERAND_SKID_EN
        else if (accept && !consume) state_d = S_TWO;
`endif
      end
`ifdef ALU_OPERAND_SKID_EN
      S_TWO: if (consume) state_d = S_ONE;
`endif
      default: state_d = S_EMPTY;
    endcase
  end

  // ---------------- outputs / load strobes ----------------
`ifdef ALU_OPERAND_SKID_EN
  // in_ready only looks at registered state, so out_ready never reaches it
  assign in_ready = rst_n && in_rdy_q;

  always_comb begin
    ld_out_in   = 1'b0;
    ld_skid     = 1'b0;
    ld_out_skid = 1'b0;
    unique case (state_q)
      S_EMPTY: ld_out_in = accept;
      S_ONE: begin
        ld_out_in = accept && consume;
        ld_skid   = accept && !consume;
      end
      S_TWO:   ld_out_skid = consume;
      default: ;
    endcase
  end
`else
  assign in_ready = rst_n && (!out_vld_q || out_ready);

  // a new item only lands in ONE when the old one leaves the same cycle
  always_comb begin
    ld_out_in = 1'b0;
    unique case (state_q)
      S_EMPTY: ld_out_in = accept;
      S_ONE:   ld_out_in = accept && consume;
      default: ;
    endcase
  end
`endif

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         out_q <= '0;
    else if (ld_out_in) out_q <= dec;
`ifdef ALU_OPERAND_SKID_EN
    else if (ld_out_skid) out_q <= skid_q;
`endif
  end

`ifdef ALU_OPERAND_SKID_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       skid_q <= '0;
    else if (ld_skid) skid_q <= dec;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt_q <= '0;
    else if (accept && dec.err && (err_cnt_q != {ERR_CNT_W{1'b1}}))
      err_cnt_q <= err_cnt_q + 1'b1;
  end

  assign out_valid = out_vld_q;
  assign out_amod  = out_q.amod;
  assign out_bmod  = out_q.bmod;
  assign out_cin   = out_q.cin;
  assign out_err   = out_q.err;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: queue-based reference model, randomised
// and directed traffic on a WIDTH=4 instance plus a WIDTH=16 NEG_A spot check.

module tb_alu_operand_stage;
  localparam int W  = 4;
  localparam int W2 = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, out_valid, out_ready, out_cin, out_err;
  logic [W-1:0] in_a, in_b, out_amod, out_bmod, dsum;
  logic [2:0]   in_op;
  logic [7:0]   err_cnt;

  logic          v16, rdy16, ov16, ordy16, cin16, err16;
  logic [W2-1:0] a16, b16, amod16, bmod16, sum16;
  logic [2:0]    op16;
  logic [7:0]    ecnt16;

  alu_operand_stage #(.WIDTH(W), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_amod(out_amod), .out_bmod(out_bmod),
    .out_cin(out_cin), .out_err(out_err), .err_cnt(err_cnt));

  alu_operand_stage #(.WIDTH(W2), .ERR_CNT_W(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy16),
    .in_a(a16), .in_b(b16), .in_op(op16), .out_valid(ov16),
    .out_ready(ordy16), .out_amod(amod16), .out_bmod(bmod16),
    .out_cin(cin16), .out_err(err16), .err_cnt(ecnt16));

  assign dsum  = out_amod + out_bmod + {{(W-1){1'b0}}, out_cin};
  assign sum16 = amod16 + bmod16 + {{(W2-1){1'b0}}, cin16};

  typedef struct packed {
    logic [W-1:0] amod;
    logic [W-1:0] bmod;
    logic         cin;
    logic         err;
    logic [W-1:0] sum;
  } exp_t;

  exp_t q[$];
  int   model_cnt = 0;
  int   checks = 0, errors = 0;

`ifdef ALU_OPERAND_SKID_EN
  localparam int EXP_BP = 2;
`else
  localparam int EXP_BP = 1;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Expected operands from the opcode table; the sum is what the adder must produce
  function automatic exp_t ref_item(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [2:0] op);
    exp_t e;
    e = '0;
    case (op)
      3'd0: begin e.bmod = a;              e.sum = a;              end
      3'd1: begin e.bmod = ~a; e.cin = 1;  e.sum = -a;             end
      3'd2: begin e.amod = a; e.bmod = b;  e.sum = a + b;          end
      3'd3: begin e.bmod = a; e.cin = 1;   e.sum = a + W'(1);      end
      3'd4: begin e.amod = a; e.bmod = ~b; e.cin = 1; e.sum = a - b; end
      3'd5: begin e.amod = '1; e.bmod = a; e.sum = a - W'(1);      end
      3'd6: begin e.bmod = b;              e.sum = b;              end
      default: begin e.bmod = a; e.err = 1; e.sum = a;             end
    endcase
    return e;
  endfunction

  // One clock: drive at posedge+1, check at negedge, update model after the edge
  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2:0] op, input logic ordy, output logic dut_acc);
    logic exp_rdy, acc, cons;
    in_valid = v; in_a = a; in_b = b; in_op = op; out_ready = ordy;
    #4;
`ifdef ALU_OPERAND_SKID_EN
    exp_rdy = (q.size() < 2);
`else
    exp_rdy = (q.size() == 0) || ordy;
`endif
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready",  32'(in_ready),  32'(exp_rdy));
    chk("err_cnt",   32'(err_cnt),   32'(model_cnt));
    if (q.size() > 0) begin
      chk("amod", 32'(out_amod), 32'(q[0].amod));
      chk("bmod", 32'(out_bmod), 32'(q[0].bmod));
      chk("cin",  32'(out_cin),  32'(q[0].cin));
      chk("err",  32'(out_err),  32'(q[0].err));
      chk("sum",  32'(dsum),     32'(q[0].sum));
    end
    dut_acc = v && in_ready;
    acc  = v && exp_rdy;
    cons = (q.size() > 0) && ordy;
    @(posedge clk); #1;
    if (cons) void'(q.pop_front());
    if (acc) begin
      q.push_back(ref_item(a, b, op));
      if (op == 3'd7 && model_cnt < 255) model_cnt++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    int   k, nacc, guard;
    in_valid = 0; in_a = '0; in_b = '0; in_op = '0; out_ready = 0;
    v16 = 0; a16 = '0; b16 = '0; op16 = '0; ordy16 = 0;

    // reset asserted
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready),  0);
    chk("rst_out_valid",32'(out_valid), 0);
    chk("rst_amod",     32'(out_amod),  0);
    chk("rst_bmod",     32'(out_bmod),  0);
    chk("rst_cin",      32'(out_cin),   0);
    chk("rst_err",      32'(out_err),   0);
    chk("rst_err_cnt",  32'(err_cnt),   0);
    chk("rst16_ready",  32'(rdy16),     0);
    @(posedge clk); #3 rst_n = 1'b1;
    #1;
    chk("idle_in_ready", 32'(in_ready),  1);
    chk("idle_out_valid",32'(out_valid), 0);
    chk("idle16_ready",  32'(rdy16),     1);
    @(posedge clk); #1;

    // WIDTH=16 NEG_A of 1
    v16 = 1; a16 = 16'h0001; b16 = 16'h1234; op16 = 3'b001; ordy16 = 1;
    @(posedge clk); #1;
    v16 = 0;
    chk("w16_valid", 32'(ov16),   1);
    chk("w16_amod",  32'(amod16), 32'h0000);
    chk("w16_bmod",  32'(bmod16), 32'hFFFE);
    chk("w16_cin",   32'(cin16),  1);
    chk("w16_err",   32'(err16),  0);
    chk("w16_sum",   32'(sum16),  32'hFFFF);
    chk("w16_ecnt",  32'(ecnt16), 0);

    // streaming, every op back to back
    for (int op = 0; op < 7; op++) step(1'b1, 4'd5, 4'd3, 3'(op), 1'b1, acc);
    step(1'b0, '0, '0, '0, 1'b1, acc);
    step(1'b0, '0, '0, '0, 1'b1, acc);

    // back-pressure with ADD A=1..4
    k = 1; nacc = 0;
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 4'(k), 4'd2, 3'd2, 1'b0, acc);
      if (acc) begin k++; nacc++; end
    end
    chk("bp_accepted", 32'(nacc), 32'(EXP_BP));
    guard = 0;
    while (k <= 4 && guard < 20) begin
      step(1'b1, 4'(k), 4'd2, 3'd2, 1'b1, acc);
      if (acc) k++;
      guard++;
    end
    chk("bp_drained", 32'(k), 5);
    for (int c = 0; c < 3; c++) step(1'b0, '0, '0, '0, 1'b1, acc);

    // reserved opcode saturation
    for (int i = 0; i < 300; i++) step(1'b1, 4'($urandom), 4'($urandom), 3'd7, 1'b1, acc);
    step(1'b0, '0, '0, '0, 1'b1, acc);
    chk("err_sat", 32'(err_cnt), 255);

    // random traffic
    for (int i = 0; i < 200; i++)
      step(1'($urandom), 4'($urandom), 4'($urandom), 3'($urandom),
           1'($urandom_range(0, 3) != 0), acc);

    // reset mid-stream with the stage full
    for (int c = 0; c < 4; c++) step(1'b0, '0, '0, '0, 1'b1, acc);
    step(1'b1, 4'd7, 4'd1, 3'd2, 1'b0, acc);
    step(1'b1, 4'd8, 4'd1, 3'd2, 1'b0, acc);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_out_valid", 32'(out_valid), 0);
    chk("mid_in_ready",  32'(in_ready),  0);
    chk("mid_amod",      32'(out_amod),  0);
    chk("mid_bmod",      32'(out_bmod),  0);
    chk("mid_cin",       32'(out_cin),   0);
    chk("mid_err",       32'(out_err),   0);
    chk("mid_err_cnt",   32'(err_cnt),   0);
    q.delete();
    model_cnt = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    step(1'b1, 4'd9, 4'd4, 3'd2, 1'b1, acc);
    step(1'b0, '0, '0, '0, 1'b1, acc);
    step(1'b0, '0, '0, '0, 1'b1, acc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Parametrised, pipelined operand pre-processing stage for the ALU datapath. Decodes a 3-bit opcode into the two adder operands and an adder carry-in. Results are registered behind a valid/ready handshake so the stage sits between the operand fetch and the adder. Generalises the fixed 4-bit combinational operand selector to any width, adds subtract/decrement/pass-B modes and a reserved-opcode error counter.

## Interface
- `WIDTH`, default 4: operand width in bits; must be ≥ 2.
- `ERR_CNT_W`, default 8: width of the reserved-opcode error counter.
- `clk` input, 1 bit: the single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: `in_a`/`in_b`/`in_op` are valid.
- `in_ready` output, 1 bit: the stage accepts an input this cycle.
- `in_a` input, WIDTH bits: operand A.
- `in_b` input, WIDTH bits: operand B.
- `in_op` input, 3 bits: opcode.
- `out_valid` output, 1 bit: `out_amod`/`out_bmod`/`out_cin`/`out_err` are valid.
- `out_ready` input, 1 bit: the downstream adder consumes the output this cycle.
- `out_amod` output, WIDTH bits: adder operand 1.
- `out_bmod` output, WIDTH bits: adder operand 2.
- `out_cin` output, 1 bit: adder carry-in.
- `out_err` output, 1 bit: the item carried a reserved opcode.
- `err_cnt` output, ERR_CNT_W bits: count of accepted reserved opcodes; saturates.

## Operation
- Transfer rules: an input is accepted when `in_valid && in_ready`. An output is consumed when `out_valid && out_ready`.
- Decode is combinational on the inputs. The decoded values are captured on acceptance. The adder then computes `amod + bmod + cin`, modulo 2^WIDTH.
- 000 PASS_A: amod = 0, bmod = A, cin = 0.
- 001 NEG_A: amod = 0, bmod = ~A, cin = 1 (two's complement of A).
- 010 ADD: amod = A, bmod = B, cin = 0.
- 011 INC_A: amod = 0, bmod = A, cin = 1.
- 100 SUB: amod = A, bmod = ~B, cin = 1.
- 101 DEC_A: amod = all-ones, bmod = A, cin = 0.
- 110 PASS_B: amod = 0, bmod = B, cin = 0.
- 111 reserved:
  - Decoded as PASS_A with `out_err` = 1.
  - On acceptance, `err_cnt` increments and holds at 2^ERR_CNT_W − 1.
- Items leave in acceptance order. No item is dropped or duplicated.
- Storage states:
  - EMPTY: `out_valid` = 0.
  - ONE: output register holds an item.
  - TWO: output register and skid register both hold items; only with skid enabled.
- State transitions:
  - EMPTY + accept → ONE.
  - ONE + accept and consume → ONE, with the new item in the output register.
  - ONE + consume only → EMPTY.
  - ONE + accept, no consume → TWO.
  - TWO + consume → ONE, with the skid item moved into the output register.
- Output register contents do not change while `out_valid && !out_ready`.
- Reset (asynchronous, any time, including mid-stream):
  - State → EMPTY; held items are discarded.
  - `out_valid` = 0, `in_ready` = 1 while `rst_n` is high after release.
  - `out_amod`, `out_bmod`, `out_cin`, `out_err`, `err_cnt` = 0.
  - `in_ready` = 0 while `rst_n` is low.

## Timing
- Latency: 1 cycle. An input accepted at edge N is presented with `out_valid` = 1 after edge N.
- Throughput: 1 item per cycle while `out_ready` = 1.
- `out_valid` and all `out_*` signals come straight from registers.
- Simultaneous accept and consume in the same cycle is always legal.
- `err_cnt` updates on the same edge that accepts the reserved opcode.

## Configuration
- `ALU_OPERAND_SKID_EN` defined:
  - A 2-entry skid buffer (output register plus skid register) is present.
  - `in_ready` is registered: `in_ready` = 1 unless the state is TWO.
  - No combinational path from `out_ready` to `in_ready`.
- `ALU_OPERAND_SKID_EN` undefined:
  - Single output register; state TWO does not exist.
  - `in_ready` = `!out_valid || out_ready`, combinational.
  - Same data, ordering and latency.

## Test plan
- Reset then idle, WIDTH = 4 → `out_valid` = 0, `in_ready` = 1, `err_cnt` = 0, all data outputs 0.
- Streaming with `out_ready` = 1, WIDTH = 4, A = 5, B = 3, ops 000..110 on consecutive cycles → one output per cycle, (amod, bmod, cin) matching the op list, e.g. SUB = (5, 12, 1) and DEC_A = (15, 5, 0). Adder sums: 5, 11, 8, 6, 2, 4, 3.
- Back-pressure: hold `out_ready` = 0 for 3 cycles while driving ADD A = 1..4 → exactly 2 accepted with skid enabled, 1 without. `out_amod` holds 1 until consumed. After release, outputs appear in order with no loss.
- Reserved op: 300 accepted items with op 111, ERR_CNT_W = 8 → `out_err` = 1 on each, PASS_A data, `err_cnt` stops at 255.
- Reset mid-stream: assert `rst_n` = 0 in state TWO for 1 cycle → outputs immediately 0, `out_valid` = 0. The first item accepted after release is the next one output.
- WIDTH = 16: NEG_A with A = 0x0001 → amod 0x0000, bmod 0xFFFE, cin 1, sum 0xFFFF.
